// File: rtl/program_memory_responder.sv
// ----------------------------------------------------------------------------
// program_memory_responder: program RAM, byte-serial host loader and MMIO ports
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module program_memory_responder #(
  parameter int          DEPTH       = 4096,
  parameter logic [11:0] IO_OUT_ADDR = 12'hFFE,
  parameter logic [11:0] IO_IN_ADDR  = 12'hFFF
) (
  input  logic        clock,
  input  logic        not_reset,
  input  logic [11:0] address,
  output logic [15:0] rdata,
  input  logic [15:0] wdata,
  input  logic        memory_write,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        cpu_not_reset,
  input  logic [15:0] in_port,
  output logic [15:0] out_port,
  output logic        out_strobe
);

  localparam logic [1:0]  LOAD_HI  = 2'd0;
  localparam logic [1:0]  LOAD_LO  = 2'd1;
  localparam logic [1:0]  RUN      = 2'd2;
  localparam logic [11:0] LAST_PTR = 12'(DEPTH - 1);

  logic [1:0]  state_q, state_d;
  logic [11:0] ptr_q, ptr_d;
  logic [7:0]  held_q, held_d;
  logic [15:0] out_port_q, out_port_d;
  logic        out_strobe_q, out_strobe_d;
  logic        cpu_not_reset_q, cpu_not_reset_d;
  logic [15:0] sync1_q, sync2_q;

  logic        ram_we;
  logic [11:0] ram_waddr;
  logic [15:0] ram_wdata;
  logic [15:0] ram [DEPTH];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    held_d       = held_q;
    out_port_d   = out_port_q;
    out_strobe_d = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = ptr_q;
    ram_wdata    = 16'h0000;

    case (state_q)
      LOAD_HI: begin
        if (load_valid) begin
          held_d = load_byte;
          if (load_last) begin
            ram_we    = 1'b1;
            ram_wdata = {load_byte, 8'h00};
            state_d   = RUN;
          end else begin
            state_d = LOAD_LO;
          end
        end
      end
      LOAD_LO: begin
        if (load_valid) begin
          ram_we    = 1'b1;
          ram_wdata = {held_q, load_byte};
          // Pointer saturates at the last word so the loader can never wrap.
          if (ptr_q != LAST_PTR) begin
            ptr_d = ptr_q + 12'd1;
          end
          if (load_last || (ptr_q == LAST_PTR)) begin
            state_d = RUN;
          end else begin
            state_d = LOAD_HI;
          end
        end
      end
      RUN: begin
        if (memory_write) begin
          if (address == IO_OUT_ADDR) begin
            out_port_d   = wdata;
            out_strobe_d = 1'b1;
          end else if (address != IO_IN_ADDR) begin
            ram_we    = 1'b1;
            ram_waddr = address;
            ram_wdata = wdata;
          end
        end
      end
      default: begin
        state_d = LOAD_HI;
      end
    endcase

    cpu_not_reset_d = (state_d == RUN);
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state_q         <= LOAD_HI;
      ptr_q           <= 12'h000;
      held_q          <= 8'h00;
      out_port_q      <= 16'h0000;
      out_strobe_q    <= 1'b0;
      cpu_not_reset_q <= 1'b0;
      sync1_q         <= 16'h0000;
      sync2_q         <= 16'h0000;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      held_q          <= held_d;
      out_port_q      <= out_port_d;
      out_strobe_q    <= out_strobe_d;
      cpu_not_reset_q <= cpu_not_reset_d;
      sync1_q         <= in_port;
      sync2_q         <= sync1_q;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  always_comb begin
    if (address == IO_IN_ADDR) begin
      rdata = sync2_q;
    end else if (address == IO_OUT_ADDR) begin
      rdata = out_port_q;
    end else begin
      rdata = ram[address];
    end
  end

  assign load_ready    = not_reset && (state_q != RUN);
  assign cpu_not_reset = cpu_not_reset_q;
  assign out_port      = out_port_q;
  assign out_strobe    = out_strobe_q;

endmodule

`default_nettype wire
